// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the sequence decoder: FSM state encoding,
// step-counter width and the Gray-to-binary conversion used by both
// the input decode path and the autonomous scan path.
package seq_decoder_pkg;

  // Widest code the decoder supports; the Gray converter works on this width.
  localparam int GRAY_MAX_W = 6;

  // Step counter width: holds SCAN_DIV-1 for SCAN_DIV up to 255.
  localparam int SCAN_CNT_W = 8;

  // IDLE accepts codes from the input port; SCAN publishes indices autonomously.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  // Narrower codes are zero-extended by the caller, which leaves the low bits
  // of the result identical to a native-width conversion.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/seq_decoder_onehot_map.sv
// Combinational index-to-one-hot map, shared by the decode and scan paths.
module onehot_map
#(
  parameter int N = 2
)
(
  input  logic [N-1:0]      idx,
  output logic [(1<<N)-1:0] onehot
);

  // One comparator per output bit; exactly one matches for any index value.
  for (genvar gi = 0; gi < (1 << N); gi++) begin : g_bit
    localparam logic [N-1:0] BIT_IDX = N'(gi);
    assign onehot[gi] = (idx == BIT_IDX);
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequence decoder: turns an N-bit code (binary or Gray ordered) into a
// registered one-hot output with single-cycle latency, or, while scan_en is
// held, steps autonomously through every index every SCAN_DIV cycles.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic              gray_mode,
  input  logic              scan_en,
  output logic [(1<<N)-1:0] out_onehot,
  output logic [N-1:0]      out_code,
  output logic              out_valid
);

  localparam int W = 1 << N;

  // Value loaded after each scan step so the next one lands SCAN_DIV cycles later.
  localparam logic [SCAN_CNT_W-1:0] STEP_RELOAD = SCAN_CNT_W'(SCAN_DIV - 1);

  state_t                state_reg,      state_next;
  logic [SCAN_CNT_W-1:0] step_cnt_reg,   step_cnt_next;
  logic [N-1:0]          scan_idx_reg,   scan_idx_next;
  logic [W-1:0]          out_onehot_reg, out_onehot_next;
  logic [N-1:0]          out_code_reg,   out_code_next;
  logic                  out_valid_reg,  out_valid_next;

  logic [N-1:0] in_code_bin;
  logic [N-1:0] scan_idx_bin;
  logic [N-1:0] decode_idx;
  logic [N-1:0] scan_map_idx;
  logic [N-1:0] map_idx;
  logic [W-1:0] map_onehot;
  logic         transfer;
  logic         scan_step;

  // Gray conversion of both candidate codes; gray_mode is applied in the same
  // cycle as the code it qualifies, so no mode state is kept.
  assign in_code_bin  = N'(gray_to_bin(GRAY_MAX_W'(in_code)));
  assign scan_idx_bin = N'(gray_to_bin(GRAY_MAX_W'(scan_idx_reg)));
  assign decode_idx   = gray_mode ? in_code_bin  : in_code;
  assign scan_map_idx = gray_mode ? scan_idx_bin : scan_idx_reg;

  // Ready only in IDLE and only when no scan is being requested; a scan
  // request in the same cycle wins over a pending code. Reset forces it low.
  assign in_ready  = !rst && (state_reg == IDLE) && !scan_en;
  assign transfer  = in_valid && in_ready;

  // A scan step fires whenever the interval counter has run down to zero.
  assign scan_step = (state_reg == SCAN) && scan_en && (step_cnt_reg == '0);

  // The single one-hot map is steered to whichever path owns the output.
  assign map_idx = (state_reg == SCAN) ? scan_map_idx : decode_idx;

  onehot_map #(
    .N (N)
  ) u_onehot_map (
    .idx    (map_idx),
    .onehot (map_onehot)
  );

  // Next-state and next-output logic for the IDLE/SCAN controller.
  always_comb begin
    state_next      = state_reg;
    step_cnt_next   = step_cnt_reg;
    scan_idx_next   = scan_idx_reg;
    out_onehot_next = out_onehot_reg;
    out_code_next   = out_code_reg;
    out_valid_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (scan_en) begin
          // Counter at zero makes the first step fire on the next cycle.
          state_next    = SCAN;
          step_cnt_next = '0;
          scan_idx_next = '0;
        end else if (transfer) begin
          out_onehot_next = map_onehot;
          out_code_next   = map_idx;
          out_valid_next  = 1'b1;
        end
      end

      SCAN: begin
        if (!scan_en) begin
          // Leaving scan drops any partial interval and blanks the outputs
          // silently, so a later entry restarts cleanly at index 0.
          state_next      = IDLE;
          step_cnt_next   = '0;
          scan_idx_next   = '0;
          out_onehot_next = '0;
          out_code_next   = '0;
        end else if (scan_step) begin
          out_onehot_next = map_onehot;
          out_code_next   = map_idx;
          out_valid_next  = 1'b1;
          // Natural N-bit overflow gives the wrap to 0 with no extra cycle.
          scan_idx_next   = scan_idx_reg + 1'b1;
          step_cnt_next   = STEP_RELOAD;
        end else begin
          step_cnt_next   = step_cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      step_cnt_reg   <= '0;
      scan_idx_reg   <= '0;
      out_onehot_reg <= '0;
      out_code_reg   <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      step_cnt_reg   <= step_cnt_next;
      scan_idx_reg   <= scan_idx_next;
      out_onehot_reg <= out_onehot_next;
      out_code_reg   <= out_code_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign out_onehot = out_onehot_reg;
  assign out_code   = out_code_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: an N=2/SCAN_DIV=4 instance with a
// cycle-tagged scoreboard, plus an N=3 instance for the wide Gray case.
module tb_seq_decoder;

  localparam int N        = 2;
  localparam int W        = 1 << N;
  localparam int SCAN_DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, gray_mode, scan_en, out_valid;
  logic [N-1:0] in_code, out_code;
  logic [W-1:0] out_onehot;

  logic         in_valid3, in_ready3, gray_mode3, scan_en3, out_valid3;
  logic [2:0]   in_code3, out_code3;
  logic [7:0]   out_onehot3;

  typedef struct {
    int           cyc;
    logic [W-1:0] oh;
    logic [N-1:0] code;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] last_oh;
  logic [N-1:0] last_code;

  seq_decoder #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .gray_mode(gray_mode), .scan_en(scan_en),
    .out_onehot(out_onehot), .out_code(out_code), .out_valid(out_valid)
  );

  seq_decoder #(.N(3), .SCAN_DIV(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_code(in_code3), .gray_mode(gray_mode3), .scan_en(scan_en3),
    .out_onehot(out_onehot3), .out_code(out_code3), .out_valid(out_valid3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int c, input int idx);
    exp_t e;
    logic [W-1:0] one;
    one    = 1;
    e.cyc  = c;
    e.oh   = one << idx;
    e.code = N'(idx);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_code = 2'd3; gray_mode = 1'b0; scan_en = 1'b0;
    in_valid3 = 1'b1; in_code3 = 3'd5; gray_mode3 = 1'b0; scan_en3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_onehot !== '0 || out_code !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got onehot=%b code=%0d valid=%b, want 0 0 0", out_onehot, out_code, out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%b, want 0", in_ready);
    end
    n_checks++;
    if (out_onehot3 !== 8'h00 || out_code3 !== 3'd0 || out_valid3 !== 1'b0 || in_ready3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_n3: got onehot=%b code=%0d valid=%b ready=%b, want 0 0 0 0", out_onehot3, out_code3, out_valid3, in_ready3);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got in_ready=%b, want 1", in_ready);
    end
    scan_en = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_follows_scan_en: got in_ready=%b, want 0", in_ready);
    end
    scan_en = 1'b0;
    last_oh = '0; last_code = '0;
    $display("test_reset done");
  endtask

  task automatic test_n3_gray();
    @(posedge clk); #1;
    in_valid3 = 1'b1; in_code3 = 3'b100; gray_mode3 = 1'b1;
    #1;
    n_checks++;
    if (in_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL n3_ready: got in_ready=%b, want 1", in_ready3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid3 !== 1'b1 || out_onehot3 !== 8'h80 || out_code3 !== 3'd7) begin
      n_fail++;
      $display("FAIL n3_gray_100: got valid=%b onehot=%b code=%0d, want 1 10000000 7", out_valid3, out_onehot3, out_code3);
    end
    in_code3 = 3'd5; gray_mode3 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid3 !== 1'b1 || out_onehot3 !== 8'h20 || out_code3 !== 3'd5) begin
      n_fail++;
      $display("FAIL n3_binary_5: got valid=%b onehot=%b code=%0d, want 1 00100000 5", out_valid3, out_onehot3, out_code3);
    end
    in_valid3 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid3 !== 1'b0 || out_onehot3 !== 8'h20 || out_code3 !== 3'd5) begin
      n_fail++;
      $display("FAIL n3_hold: got valid=%b onehot=%b code=%0d, want 0 00100000 5", out_valid3, out_onehot3, out_code3);
    end
    $display("test_n3_gray done");
  endtask

  task automatic test_binary();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL binary cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL binary_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i < 4) begin
        in_valid = 1'b1; in_code = N'(i); gray_mode = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL binary_ready cyc=%0d: got in_ready=%b, want 1", cyc, in_ready);
        end
        push_exp(cyc + 1, i);
      end else begin
        in_valid = 1'b0;
      end
    end
    $display("test_binary done");
  endtask

  task automatic test_gray();
    int gray_tbl [4] = '{0, 1, 3, 2};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL gray cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL gray_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i < 4) begin
        in_valid = 1'b1; in_code = N'(gray_tbl[i]); gray_mode = 1'b1;
        push_exp(cyc + 1, i);
      end else begin
        in_valid = 1'b0; gray_mode = 1'b0;
      end
    end
    $display("test_gray done");
  endtask

  task automatic test_back_to_back();
    logic gm_tbl  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   code_tbl[5] = '{2, 2, 1, 3, 1};
    int   idx_tbl [5] = '{2, 3, 1, 2, 1};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL back_to_back cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL back_to_back_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i < 5) begin
        in_valid = 1'b1; in_code = N'(code_tbl[i]); gray_mode = gm_tbl[i];
        push_exp(cyc + 1, idx_tbl[i]);
      end else begin
        in_valid = 1'b0; gray_mode = 1'b0;
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_scan();
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL scan cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL scan_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i == 0) begin
        scan_en = 1'b1; in_valid = 1'b0; gray_mode = 1'b0;
        for (int k = 0; k < 5; k++) push_exp(cyc + 2 + SCAN_DIV * k, k % 4);
      end else if (i == 20) begin
        scan_en = 1'b0;
        last_oh = '0; last_code = '0;
      end
      #1;
      n_checks++;
      if (in_ready !== ((i <= 20) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL scan_ready cyc=%0d: got in_ready=%b, want %b", cyc, in_ready, (i <= 20) ? 1'b0 : 1'b1);
      end
    end
    $display("test_scan done");
  endtask

  task automatic test_scan_priority();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL priority cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL priority_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i == 0) begin
        scan_en = 1'b1; in_valid = 1'b1; in_code = 2'd3; gray_mode = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL priority_ready cyc=%0d: got in_ready=%b, want 0", cyc, in_ready);
        end
        push_exp(cyc + 2, 0);
      end else if (i == 2) begin
        scan_en = 1'b0; in_valid = 1'b0;
        last_oh = '0; last_code = '0;
      end
    end
    $display("test_scan_priority done");
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_onehot !== exp_q[0].oh || out_code !== exp_q[0].code) begin
          n_fail++;
          $display("FAIL mid_scan_reset cyc=%0d: got valid=%b onehot=%b code=%0d, want 1 %b %0d", cyc, out_valid, out_onehot, out_code, exp_q[0].oh, exp_q[0].code);
        end
        last_oh = exp_q[0].oh; last_code = exp_q[0].code;
        void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (out_valid !== 1'b0 || out_onehot !== last_oh || out_code !== last_code) begin
          n_fail++;
          $display("FAIL mid_scan_reset_hold cyc=%0d: got valid=%b onehot=%b code=%0d, want 0 %b %0d", cyc, out_valid, out_onehot, out_code, last_oh, last_code);
        end
      end
      if (i == 0) begin
        scan_en = 1'b1; in_valid = 1'b0; gray_mode = 1'b0;
        for (int k = 0; k < 3; k++) push_exp(cyc + 2 + SCAN_DIV * k, k);
      end else if (i == 10) begin
        rst = 1'b1;
        last_oh = '0; last_code = '0;
      end else if (i == 11) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_scan_reset_ready cyc=%0d: got in_ready=%b, want 0", cyc, in_ready);
        end
        rst = 1'b0; scan_en = 1'b0; in_valid = 1'b1; in_code = 2'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL post_reset_ready cyc=%0d: got in_ready=%b, want 1", cyc, in_ready);
        end
        push_exp(cyc + 1, 1);
      end else if (i == 12) begin
        in_valid = 1'b0;
      end
    end
    $display("test_reset_mid_scan done");
  endtask

  initial begin
    test_reset();
    test_n3_gray();
    test_binary();
    test_gray();
    test_back_to_back();
    test_scan();
    test_scan_priority();
    test_reset_mid_scan();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding outputs, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
